// File: rtl/pkg_rx_palabra.sv
// pkg_rx_palabra: shared types, sizes and divider helper for the palabra receiver (RX_PARITY_EN adds the PARITY state)
package pkg_rx_palabra;
  localparam int DATA_BITS = 8;
  localparam int WORD_BITS = 7;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } rx_state_t;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/module_baud_tick.sv
// module_baud_tick: one-cycle tick every DIV clocks; restart_i realigns the phase to the current cycle
module module_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);
  localparam int W = $clog2(DIV + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(DIV - 1);
  assign cnt_d  = (restart_i || tick_o) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/module_rx_palabra.sv
// module_rx_palabra: oversampling serial receiver for one Hamming(7,4) codeword per frame
// Optional even-parity bit before stop when RX_PARITY_EN is defined.
module module_rx_palabra
  import pkg_rx_palabra::*;
#(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [WORD_BITS-1:0] palabra_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);
  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL = SW'(OVERSAMPLE - 1);
  logic [1:0]           sync_q;
  logic                 rx_s, tick, restart, good;
  rx_state_t            state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [WORD_BITS-1:0] pal_q, pal_d;
  logic                 valid_q, valid_d, err_q, err_d;
  assign rx_s = sync_q[1];
  // a start edge coinciding with the valid pulse is ignored; WAIT_IDLE needs a full quiet tick period
  assign restart = (state_q == IDLE && !rx_s && !valid_q) || (state_q == WAIT_IDLE && !rx_s);
  module_baud_tick #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart_i(restart),
    .tick_o   (tick)
  );
`ifdef RX_PARITY_EN
  logic par_q, par_d;
  assign good = rx_s && !sh_q[DATA_BITS-1] && (par_q == ^sh_q);
`else
  assign good = rx_s && !sh_q[DATA_BITS-1];
`endif
  always_comb begin
    state_d = state_q;
    scnt_d  = (tick && state_q != IDLE) ? scnt_q + SW'(1) : scnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    pal_d   = pal_q;
    valid_d = 1'b0;
    err_d   = err_q;
`ifdef RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (restart) begin
        state_d = START;
        scnt_d  = '0;
      end
      START: if (tick && scnt_q == HALF) begin
        scnt_d  = '0;
        bcnt_d  = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick && scnt_q == FULL) begin
        scnt_d = '0;
        sh_d   = {rx_s, sh_q[DATA_BITS-1:1]};
        bcnt_d = bcnt_q + BW'(1);
`ifdef RX_PARITY_EN
        if (bcnt_q == BW'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (bcnt_q == BW'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef RX_PARITY_EN
      PARITY: if (tick && scnt_q == FULL) begin
        scnt_d  = '0;
        par_d   = rx_s;
        state_d = STOP;
      end
`endif
      STOP: if (tick && scnt_q == FULL) begin
        scnt_d  = '0;
        pal_d   = good ? sh_q[WORD_BITS-1:0] : pal_q;
        valid_d = good;
        err_d   = !good;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (tick && rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      pal_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      pal_q   <= pal_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  assign palabra_o   = pal_q;
  assign valid_o     = valid_q;
  assign frame_err_o = err_q;
  assign busy_o      = state_q != IDLE;
endmodule
